load_store_controller: RTL and testbench

LOAD_STORE_CONTROLLER -- requirements
Module: load_store_controller

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_extend.sv | 27 ++
 rtl/load_store_controller.sv | 138 +++++++++++++
 tb/tb_load_store_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, size encodings and request bundle
// for the byte-serial load/store controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT_RD,
      DONE
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
   } lsu_req_t;

   // size 2'b11 behaves as a word
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      unique case (1'b1)
         (size == SZ_BYTE): return 3'd1;
         (size == SZ_HALF): return 3'd2;
         (size == SZ_WORD): return 3'd4;
         default:           return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of a raw little-endian
// load value to 32 bits according to access size.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] ext
);

   logic sb;
   logic sh;

   assign sb = ~uns & raw[7];
   assign sh = ~uns & raw[15];

   always_comb begin
      ext = raw;
      unique case (1'b1)
         (size == SZ_BYTE): ext = {{24{sb}}, raw[7:0]};
         (size == SZ_HALF): ext = {{16{sh}}, raw[15:0]};
         default:           ext = raw;
      endcase
   end

endmodule

// File: rtl/load_store_controller.sv
// load_store_controller: byte-serial load/store unit for an 8-bit
// data memory. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_controller
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  misalign_err,
   output logic                  busy
);

   lsu_state_e            state;
   lsu_state_e            state_nxt;
   lsu_req_t              req_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            k_q;
   logic [31:0]           ld_buf;
   logic                  cap_en;
   logic [1:0]            cap_idx;
   logic [31:0]           hold_q;
   logic [31:0]           ext_val;
   logic [31:0]           done_val;
   logic                  accept;
   logic                  last;
   logic                  mis;
   logic                  unused_addr;

   assign accept      = req_valid && (state == IDLE);
   assign last        = ({1'b0, k_q} == byte_count(req_q.size) - 3'd1);
   assign unused_addr = ^req_addr[31:ADDR_WIDTH];

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;

   assign mis = ((req_size == SZ_HALF) && req_addr[0])
             || (req_size[1] && (req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= mis;
      end
   end

   assign misalign_err = resp_valid && err_q;
`else
   assign mis          = 1'b0;
   assign misalign_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid) state_nxt = mis ? DONE : ACCESS;
         ACCESS:  if (last) state_nxt = req_q.we ? DONE : WAIT_RD;
         WAIT_RD: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
      endcase
   end

   // read data lags its address by one cycle; cap_* remember the slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         addr_q  <= '0;
         k_q     <= '0;
         ld_buf  <= '0;
         cap_en  <= 1'b0;
         cap_idx <= '0;
         hold_q  <= '0;
      end else begin
         cap_en  <= (state == ACCESS) && !req_q.we;
         cap_idx <= k_q;
         if (accept) begin
            req_q.we    <= req_we;
            req_q.size  <= req_size;
            req_q.uns   <= req_unsigned;
            req_q.wdata <= req_wdata;
            addr_q      <= req_addr[ADDR_WIDTH-1:0];
            k_q         <= '0;
            ld_buf      <= '0;
         end else if (state == ACCESS) begin
            k_q <= last ? 2'd0 : k_q + 2'd1;
         end
         if (cap_en) begin
            ld_buf[8*cap_idx +: 8] <= mem_rdata;
         end
         if (state == DONE) begin
            hold_q <= done_val;
         end
      end
   end

   assign mem_en    = (state == ACCESS);
   assign mem_we    = mem_en && req_q.we;
   assign mem_addr  = mem_en ? addr_q + ADDR_WIDTH'(k_q) : '0;
   assign mem_wdata = mem_en ? req_q.wdata[8*k_q +: 8] : '0;

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);

   lsu_extend u_ext (
      .raw  (ld_buf),
      .size (req_q.size),
      .uns  (req_q.uns),
      .ext  (ext_val)
   );

   assign done_val   = req_q.we ? '0 : ext_val;
   assign resp_rdata = resp_valid ? done_val : hold_q;

endmodule

// File: tb/tb_load_store_controller.sv
// tb_load_store_controller: directed bench with a transaction-level
// memory/response model and a per-cycle compare process.
module tb_load_store_controller;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata = '0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          misalign_err;
   logic          busy;

   always #5 clk = ~clk;

   load_store_controller #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .misalign_err (misalign_err),
      .busy         (busy)
   );

   // attached memory: one-cycle read latency, pattern i ^ 0x5A
   logic [7:0] mem [256];
   bit         mem_init = 1'b0;
   int         en_cnt = 0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         mem_init <= 1'b1;
      end else if (mem_en) begin
         en_cnt <= en_cnt + 1;
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // transaction-level model
   logic [7:0] ref_mem [256];

   typedef struct {
      int          done;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] last_rd = '0;
   int          last_done = 0;
   logic        last_err = 1'b0;
   bit          chk_en = 1'b0;

   function automatic int nbytes(input logic [1:0] s);
      if (s == 2'b00) return 1;
      if (s == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic is_mis(input logic [1:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] s, input logic u,
                                            input logic [31:0] a);
      int          n;
      logic [31:0] v;
      n = nbytes(s);
      v = '0;
      for (int k = 0; k < n; k++) v |= 32'(ref_mem[8'(a + k)]) << (8 * k);
      if (n == 1 && !u && v[7]) v |= 32'hFFFF_FF00;
      if (n == 2 && !u && v[15]) v |= 32'hFFFF_0000;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (resp_valid) begin
            last_done = cyc;
            last_err  = misalign_err;
         end
         chk1("ready_vs_busy", req_ready, !busy);
         if (!busy) chk1("mem_en_idle", mem_en, 1'b0);
         if (!rst_n) begin
            chk1("rst_resp_valid", resp_valid, 1'b0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk1("rst_busy", busy, 1'b0);
         end else if (q.size() != 0 && q[0].done == cyc) begin
            chk1("resp_valid", resp_valid, 1'b1);
            chk("resp_rdata", resp_rdata, q[0].rd);
            chk1("misalign_err", misalign_err, q[0].err);
            last_rd = q[0].rd;
            void'(q.pop_front());
         end else begin
            chk1("resp_valid_quiet", resp_valid, 1'b0);
            chk1("misalign_err_quiet", misalign_err, 1'b0);
            chk("resp_rdata_hold", resp_rdata, last_rd);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int p);
      exp_t e;
      int   n;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      for (int i = 0; i < 100 && !req_ready; i++) step();
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready);
      end
      p = cyc + 1;
      n = nbytes(sz);
      e.err = is_mis(sz, a);
      e.rd = '0;
      if (e.err) begin
         e.done = p;
      end else if (we) begin
         e.done = p + n;
         for (int k = 0; k < n; k++) ref_mem[8'(a + k)] = wd[8*k +: 8];
      end else begin
         e.done = p + n + 1;
         e.rd = ref_load(sz, uns, a);
      end
      q.push_back(e);
      step();
   endtask

   task automatic wait_done();
      req_valid = 1'b0;
      for (int i = 0; i < 60 && q.size() != 0; i++) step();
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: pending=%0d expected 0", q.size());
         q.delete();
      end
   endtask

   int         p;
   int         p2;
   int         c0;
   int         diffs;
   logic [7:0] old2;
   logic [7:0] old3;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
      repeat (3) step();
      chk1("reset_ready", req_ready, 1'b1);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_valid", resp_valid, 1'b0);
      chk1("reset_mem_en", mem_en, 1'b0);
      chk1("reset_mis", misalign_err, 1'b0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk_en = 1'b1;
      rst_n = 1'b1;
      step();

      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, p);
      wait_done();
      chk("st_w_b0", 32'(mem[8'h10]), 32'hEF);
      chk("st_w_b1", 32'(mem[8'h11]), 32'hBE);
      chk("st_w_b2", 32'(mem[8'h12]), 32'hAD);
      chk("st_w_b3", 32'(mem[8'h13]), 32'hDE);
      chk("st_w_lat", last_done - p + 1, 5);

      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, p);
      wait_done();
      chk("ld_b_s", resp_rdata, 32'hFFFF_FFDE);
      chk("ld_b_lat", last_done - p + 1, 3);

      issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, p);
      wait_done();
      chk("ld_b_u", resp_rdata, 32'h0000_00DE);

      issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, p);
      wait_done();
      chk("ld_h_s", resp_rdata, 32'hFFFF_BEEF);
      chk("ld_h_lat", last_done - p + 1, 4);

      issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FF13, 32'h0, p);
      wait_done();
      chk("ld_b_hiaddr", resp_rdata, 32'hFFFF_FFDE);

      issue(1'b1, 2'b00, 1'b0, 32'h30, 32'hAABB_CC77, p);
      wait_done();
      chk("st_b_b0", 32'(mem[8'h30]), 32'h77);
      chk("st_b_next", 32'(mem[8'h31]), 32'h6B);
      chk("st_b_lat", last_done - p + 1, 2);

      issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234_8001, p);
      wait_done();
      issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, p);
      wait_done();
`ifndef LSU_MISALIGN_TRAP_EN
      chk("ld_h_odd", resp_rdata, 32'hFFFF_8001);
      c0 = en_cnt;
      issue(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, p);
      wait_done();
      chk("ld_w_wrap", resp_rdata, 32'h5B5A_A5A4);
      chk("ld_w_wrap_en", en_cnt - c0, 4);
`else
      c0 = en_cnt;
      issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, p);
      wait_done();
      chk("mis_no_mem", en_cnt - c0, 0);
      chk("mis_lat", last_done - p + 1, 1);
      chk1("mis_err", last_err, 1'b1);
      chk("mis_rdata", resp_rdata, 32'h0);
`endif

      issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0055, p);
      issue(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, p2);
      wait_done();
      chk("b2b_accept", p2 - p, 3);
      chk("b2b_rdata", resp_rdata, 32'h55);

      old2 = ref_mem[8'h42];
      old3 = ref_mem[8'h43];
      issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, p);
      req_valid = 1'b0;
      step();
      step();
      chk1("mid_mem_en", mem_en, 1'b1);
      chk("mid_mem_addr", 32'(mem_addr), 32'h42);
      rst_n = 1'b0;
      q.delete();
      last_rd = '0;
      ref_mem[8'h42] = old2;
      ref_mem[8'h43] = old3;
      #1;
      chk1("async_busy", busy, 1'b0);
      chk1("async_ready", req_ready, 1'b1);
      chk1("async_mem_en", mem_en, 1'b0);
      chk1("async_mem_we", mem_we, 1'b0);
      chk("async_rdata", resp_rdata, 32'h0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("rst_b0", 32'(mem[8'h40]), 32'h0D);
      chk("rst_b1", 32'(mem[8'h41]), 32'hF0);
      chk("rst_b2", 32'(mem[8'h42]), 32'h18);
      chk("rst_b3", 32'(mem[8'h43]), 32'h19);
      issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, p);
      wait_done();
      chk("post_rst_ld", resp_rdata, 32'h1918_F00D);
      chk("post_rst_lat", last_done - p + 1, 6);

      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image", diffs, 0);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
